// File: rtl/ps2_key_display_if.sv
// Bundles the PS/2 line inputs, the decoded key-event outputs and the
// multiplexed seven-segment drive of ps2_key_display.
interface ps2_key_display_if #(
    parameter int DIGITS = 4
);
    logic              ps2_clk;
    logic              ps2_data;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              key_ext;
    logic              key_break;
    logic              frame_err;
    logic [DIGITS-1:0] an;
    logic [6:0]        ca;

    // Design side: consumes the PS/2 lines, drives events and display.
    modport master (
        input  ps2_clk, ps2_data,
        output key_valid, key_code, key_ext, key_break, frame_err, an, ca
    );

    // Keyboard/observer side.
    modport slave (
        output ps2_clk, ps2_data,
        input  key_valid, key_code, key_ext, key_break, frame_err, an, ca
    );
endinterface

// File: rtl/ps2_key_display.sv
// PS/2 keyboard frame receiver with E0/F0 prefix tracking and a shifting
// multi-digit seven-segment display of the most recent key presses.
module ps2_key_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    ps2_key_display_if.master  bus
);
    localparam int IDX_W = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t       state_q, state_d;
    logic [2:0]   sync_clk_q, sync_clk_d;   // [1:0] synchroniser, [2] previous
    logic [1:0]   sync_dat_q, sync_dat_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic         pend_ext_q, pend_ext_d;
    logic         pend_brk_q, pend_brk_d;
    logic         key_valid_q, key_valid_d;
    logic [7:0]   key_code_q, key_code_d;
    logic         key_ext_q, key_ext_d;
    logic         key_break_q, key_break_d;
    logic         frame_err_q, frame_err_d;

    logic [6:0]       glyph_q [DIGITS];
    logic [6:0]       glyph_d [DIGITS];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic ps2_fall;
    logic ps2_bit;

    assign ps2_fall = sync_clk_q[2] & ~sync_clk_q[1];
    assign ps2_bit  = sync_dat_q[1];

    function automatic logic [6:0] glyph_of(input logic [7:0] code, input logic ext);
        logic [6:0] g;
        g = 7'b0111111;
        if (!ext) begin
            case (code)
                8'h45: g = 7'b1000000;
                8'h16: g = 7'b1111001;
                8'h1E: g = 7'b0100100;
                8'h26: g = 7'b0110000;
                8'h25: g = 7'b0011001;
                8'h2E: g = 7'b0010010;
                8'h36: g = 7'b0000010;
                8'h3D: g = 7'b1111000;
                8'h3E: g = 7'b0000000;
                8'h46: g = 7'b0010000;
                8'h1C: g = 7'b0001000;
                8'h1B: g = 7'b0010010;
                8'h44: g = 7'b1000000;
                8'h2B: g = 7'b0001110;
                default: g = 7'b0111111;
            endcase
        end
        return g;
    endfunction

    // Frame FSM, timeout supervision and prefix/event decoding.
    always_comb begin
        sync_clk_d  = {sync_clk_q[1:0], bus.ps2_clk};
        sync_dat_d  = {sync_dat_q[0], bus.ps2_data};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        pend_ext_d  = pend_ext_q;
        pend_brk_d  = pend_brk_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        frame_err_d = 1'b0;

        if (ps2_fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!ps2_bit) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {ps2_bit, shift_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = ps2_bit;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (ps2_bit && ((^shift_q) ^ par_q)) begin
                        if (shift_q == 8'hE0) begin
                            pend_ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            pend_brk_d = 1'b1;
                        end else begin
                            key_valid_d = 1'b1;
                            key_code_d  = shift_q;
                            key_ext_d   = pend_ext_q;
                            key_break_d = pend_brk_q;
                            pend_ext_d  = 1'b0;
                            pend_brk_d  = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (frame_err_d) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
        end
    end

    // Receiver and key-event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_clk_q  <= '1;
            sync_dat_q  <= '1;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            pend_ext_q  <= 1'b0;
            pend_brk_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_clk_q  <= sync_clk_d;
            sync_dat_q  <= sync_dat_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            pend_ext_q  <= pend_ext_d;
            pend_brk_q  <= pend_brk_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Glyph buffer shift on make events and digit scan timing.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) glyph_d[i] = glyph_q[i];
        if (key_valid_q && !key_break_q) begin
            for (int unsigned i = 1; i < DIGITS; i++) glyph_d[i] = glyph_q[i-1];
            glyph_d[0] = glyph_of(key_code_q, key_ext_q);
        end
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Display registers; glyphs reset to blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DIGITS; i++) glyph_q[i] <= '1;
            idx_q <= '0;
            div_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DIGITS; i++) glyph_q[i] <= glyph_d[i];
            idx_q <= idx_d;
            div_q <= div_d;
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_ext   = key_ext_q;
    assign bus.key_break = key_break_q;
    assign bus.frame_err = frame_err_q;
    assign bus.an        = ~(DIGITS'(1) << idx_q);
    assign bus.ca        = glyph_q[idx_q];
endmodule

// File: tb/tb_ps2_key_display.sv
// Directed bench for ps2_key_display: table of PS/2 frames with expected
// events and digit-0 glyphs, plus scan, timeout and mid-frame reset cases.
module tb_ps2_key_display;
    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_display_if #(.DIGITS(4)) bus();

    ps2_key_display #(.DIGITS(4), .REFRESH_DIV(4), .TIMEOUT_CYC(200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    int n_vec = 0;
    int n_mis = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int stop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.key_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    typedef struct packed {
        logic [7:0] b;
        bit         bad_par;
        bit         stop_v;
        int         exp_v;
        int         exp_e;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [6:0] g0;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic v, input bit mark_stop);
        @(negedge clk);
        bus.ps2_data = v;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        if (mark_stop) stop_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v, input int nbits);
        logic [10:0] f;
        f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == 10);
        bus.ps2_data = 1'b1;
    endtask

    task automatic wait_an(input logic [3:0] want, output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.an !== want && k < 64) begin
            @(negedge clk);
            k++;
        end
        ok = (k < 64);
        if (!ok) begin
            n_vec++;
            n_mis++;
            $display("FAIL wait_an: got %b expected %b (no match in 64 cycles)", bus.an, want);
        end
    endtask

    task automatic get_digit(input int d, output logic [6:0] g);
        logic [3:0] want;
        bit ok;
        want = ~(4'b0001 << d);
        wait_an(want, ok);
        g = ok ? bus.ca : 7'bxxxxxxx;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, lat;
        logic [6:0] g;
        logic [3:0] an_exp;
        bit ok;

        //            b     bpar stop v  e  code   ext brk glyph0
        vt[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0, 7'b0001000};
        vt[1]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0, 7'b0001000};
        vt[2]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0, 7'b0001000};
        vt[3]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b1, 7'b0001000};
        vt[4]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b1, 7'b0001000};
        vt[5]  = '{8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b0, 7'b0111111};
        vt[6]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 8'h75, 1'b1, 1'b0, 7'b0111111};
        vt[7]  = '{8'h45, 1'b0, 1'b0, 0, 1, 8'h75, 1'b1, 1'b0, 7'b0111111};
        vt[8]  = '{8'h44, 1'b0, 1'b1, 1, 0, 8'h44, 1'b0, 1'b0, 7'b1000000};
        vt[9]  = '{8'h16, 1'b0, 1'b1, 1, 0, 8'h16, 1'b0, 1'b0, 7'b1111001};
        vt[10] = '{8'h1E, 1'b0, 1'b1, 1, 0, 8'h1E, 1'b0, 1'b0, 7'b0100100};
        vt[11] = '{8'h26, 1'b0, 1'b1, 1, 0, 8'h26, 1'b0, 1'b0, 7'b0110000};
        vt[12] = '{8'h25, 1'b0, 1'b1, 1, 0, 8'h25, 1'b0, 1'b0, 7'b0011001};
        vt[13] = '{8'h2E, 1'b0, 1'b1, 1, 0, 8'h2E, 1'b0, 1'b0, 7'b0010010};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_key_code",  {24'd0, bus.key_code}, 32'd0);
        chk("rst_key_ext",   {31'd0, bus.key_ext}, 32'd0);
        chk("rst_key_break", {31'd0, bus.key_break}, 32'd0);
        chk("rst_an",        {28'd0, bus.an}, 32'b1110);
        chk("rst_ca",        {25'd0, bus.ca}, 32'h7F);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vt[i].b, vt[i].bad_par, vt[i].stop_v, 11);
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_valid_cnt", i), valid_cnt - v0, vt[i].exp_v);
            chk($sformatf("v%0d_err_cnt", i), err_cnt - e0, vt[i].exp_e);
            chk($sformatf("v%0d_key_code", i), {24'd0, bus.key_code}, {24'd0, vt[i].code});
            chk($sformatf("v%0d_key_ext", i), {31'd0, bus.key_ext}, {31'd0, vt[i].ext});
            chk($sformatf("v%0d_key_break", i), {31'd0, bus.key_break}, {31'd0, vt[i].brk});
            if (vt[i].exp_v != 0) begin
                lat = valid_cyc - stop_cyc;
                chk($sformatf("v%0d_latency_le4 (lat=%0d)", i, lat), {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
            end
            get_digit(0, g);
            chk($sformatf("v%0d_digit0", i), {25'd0, g}, {25'd0, vt[i].g0});
        end

        // Buffer after makes 16,1E,26,25,2E: digits 3..0 = 2,3,4,5.
        get_digit(3, g); chk("buf_digit3", {25'd0, g}, {25'd0, 7'b0100100});
        get_digit(2, g); chk("buf_digit2", {25'd0, g}, {25'd0, 7'b0110000});
        get_digit(1, g); chk("buf_digit1", {25'd0, g}, {25'd0, 7'b0011001});
        get_digit(0, g); chk("buf_digit0", {25'd0, g}, {25'd0, 7'b0010010});

        // Scan cadence: align on the 0111 -> 1110 transition, then 4 cycles per digit.
        wait_an(4'b0111, ok);
        wait_an(4'b1110, ok);
        for (int k = 0; k < 16; k++) begin
            an_exp = ~(4'b0001 << (k / 4));
            chk($sformatf("scan_an_k%0d", k), {28'd0, bus.an}, {28'd0, an_exp});
            @(negedge clk);
        end

        // Timeout: start + 5 data bits then silence.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h16, 1'b0, 1'b1, 6);
        repeat (300) @(negedge clk);
        chk("tmo_err_cnt", err_cnt - e0, 32'd1);
        chk("tmo_valid_cnt", valid_cnt - v0, 32'd0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h16, 1'b0, 1'b1, 11);
        repeat (20) @(negedge clk);
        chk("post_tmo_valid_cnt", valid_cnt - v0, 32'd1);
        chk("post_tmo_err_cnt", err_cnt - e0, 32'd0);
        chk("post_tmo_key_code", {24'd0, bus.key_code}, 32'h16);
        get_digit(0, g);
        chk("post_tmo_digit0", {25'd0, g}, {25'd0, 7'b1111001});

        // Reset in the middle of a frame discards it.
        send_frame(8'hFF, 1'b0, 1'b1, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_an", {28'd0, bus.an}, 32'b1110);
        chk("midrst_ca", {25'd0, bus.ca}, 32'h7F);
        chk("midrst_key_code", {24'd0, bus.key_code}, 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h2B, 1'b0, 1'b1, 11);
        repeat (20) @(negedge clk);
        chk("midrst_valid_cnt", valid_cnt - v0, 32'd1);
        chk("midrst_err_cnt", err_cnt - e0, 32'd0);
        chk("midrst_new_code", {24'd0, bus.key_code}, 32'h2B);
        get_digit(0, g);
        chk("midrst_digit0", {25'd0, g}, {25'd0, 7'b0001110});
        get_digit(1, g);
        chk("midrst_digit1_blank", {25'd0, g}, 32'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
